face_dispatcher: RTL
====================

# face_dispatcher

Fetches triangle faces from a synchronous vertex ROM and presents them one at a time to the `shader` block. For each face it:
- loads nine coordinate words and one colour word into output registers;
- pulses `start`;
- holds the operands stable until the shader returns `done`.

It sits between the scene-memory ROM and `shader`, acting as the initiator of the shader's start/done handshake.

## Interface
Parameters:
- ADDR_W, 12, ROM address width; face addresses wrap modulo 2^ADDR_W.
- CNT_W, 8, width of face count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  begin dispatching a frame; sampled only in IDLE.
- base_addr  in  ADDR_W  ROM address of the first word of face 0; sampled with go.
- num_faces  in  CNT_W  number of faces to dispatch; sampled with go.
- mem_addr  out  ADDR_W  ROM read address (registered).
- mem_rdata  in  16  ROM read data, valid one cycle after mem_addr is presented.
- v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z  out  16 each  vertex coordinates to shader.
- pixel_color  out  16  face colour to shader.
- start  out  1  one-cycle launch pulse to shader.
- done  in  1  shader completion.
- busy  out  1  high from go acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the last face's done.

## Operation
- Each face is 10 consecutive ROM words, in this order: v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, color.
- Face i starts at base_addr + 10·i. The address comes from a running pointer incremented by 1 per word; no multiplier. The pointer wraps modulo 2^ADDR_W.
- States:
  - IDLE: wait for go. On go, latch base_addr and num_faces, then go to FETCH. If num_faces = 0, go to FIN instead.
  - FETCH: present 10 sequential addresses, one per cycle. Capture mem_rdata into the output register selected by the word index, delayed one cycle. After the 10th capture, go to LAUNCH.
  - LAUNCH: start = 1 for exactly one cycle, then go to WAIT.
  - WAIT: wait for done. On done, decrement the remaining-face count. If it is nonzero, go to FETCH with the pointer continuing; otherwise go to FIN.
  - FIN: frame_done = 1 for one cycle, then go to IDLE.
- Input and output handling:
  - done is ignored outside WAIT, including in the LAUNCH cycle itself.
  - go is ignored unless the block is in IDLE.
  - Vertex and colour outputs change only during FETCH. They hold their values through LAUNCH and WAIT, and after the frame ends.
- Reset values: all outputs 0, state IDLE, busy 0.
  - Reset mid-frame abandons the frame immediately: no start, and no frame_done.

## Timing
- Edge E0 samples go. mem_addr = base_addr during the cycle after E0, advancing by 1 per cycle for 10 cycles.
- Words are captured on edges E2 through E11. start is high in the cycle following E11.
- Every output word is valid and stable no later than the start cycle.
- A done sampled at edge D in WAIT puts the next face's first address on mem_addr in the cycle after D. The next start follows 11 edges after D.
- frame_done is high in the cycle after the final done edge. busy falls together with frame_done's deassertion (busy is low in the cycle after FIN).
- With num_faces = 0: frame_done is high in the cycle after E0, and start never asserts.
- Per-face overhead is 12 cycles plus the shader latency.

## Structure
- Shared package `shader_pkg` holds:
  - `WORDS_PER_FACE = 10`.
  - The word-index enum (`W_V1X` … `W_COLOR`).
  - The dispatcher state enum `{IDLE, FETCH, LAUNCH, WAIT, FIN}`.
  - The 16-bit coordinate typedef `coord_t`, shared with `shader`.
- Single flat module. The register bank and address counter are small, so no sub-module is needed.

## Test plan
- One face at base 0, with ROM words 0x27fc, 0x1b5f, 0x0178, 0x315f, 0x1b57, 0x0178, 0x30a9, 0x1ab2, 0x017b, 0x0001:
  - outputs match word-for-word, with pixel_color = 0x0001;
  - start is high for exactly one cycle, 11 edges after go;
  - a model shader answering done 20 cycles later gives frame_done one cycle after done.
- num_faces = 3, base 0x100:
  - mem_addr sequences are 0x100–0x109, 0x10A–0x113, 0x114–0x11D;
  - exactly 3 start pulses, each only after the previous done;
  - 1 frame_done.
- num_faces = 0: frame_done is high the cycle after go; start, mem_addr and busy stay 0.
- Handshake robustness:
  - done asserted during FETCH and in the LAUNCH cycle is ignored, with no premature advance;
  - go pulsed while busy has no effect;
  - outputs stay stable throughout WAIT.
- Reset asserted in the 5th FETCH cycle of face 2:
  - all outputs are 0 the next cycle, with no start and no frame_done;
  - a new go restarts cleanly from the new base_addr.
- Base 0xFFB (ADDR_W = 12), 1 face: addresses run 0xFFB–0xFFF, then 0x000–0x004, and data is captured correctly across the wrap.

Source files
------------

// File: rtl/shader_pkg.sv
// Types shared by the face dispatcher and the shader: face layout, word order and FSM states.
package shader_pkg;

  localparam int WORDS_PER_FACE = 10;

  typedef logic [15:0] coord_t;

  // Order of the words of one face as they sit in scene memory
  typedef enum logic [3:0] {
    W_V1X   = 4'd0,
    W_V1Y   = 4'd1,
    W_V1Z   = 4'd2,
    W_V2X   = 4'd3,
    W_V2Y   = 4'd4,
    W_V2Z   = 4'd5,
    W_V3X   = 4'd6,
    W_V3Y   = 4'd7,
    W_V3Z   = 4'd8,
    W_COLOR = 4'd9
  } word_idx_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    WAIT,
    FIN
  } disp_state_e;

endpackage

// File: rtl/face_dispatcher.sv
// Streams triangle faces from the vertex ROM into operand registers and runs the
// start/done handshake with the shader, one face at a time.
module face_dispatcher
  import shader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_faces,
  output logic [ADDR_W-1:0] mem_addr,
  input  coord_t            mem_rdata,
  output coord_t            v1x,
  output coord_t            v1y,
  output coord_t            v1z,
  output coord_t            v2x,
  output coord_t            v2y,
  output coord_t            v2z,
  output coord_t            v3x,
  output coord_t            v3y,
  output coord_t            v3z,
  output coord_t            pixel_color,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [3:0] LAST_ISSUE = 4'(WORDS_PER_FACE - 1);
  localparam logic [3:0] LAST_FCNT  = 4'(WORDS_PER_FACE);

  disp_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;
  logic [3:0]        fcnt;
  word_idx_e         cap_idx;

  // ROM data lags its address by one cycle and fcnt trails the issue by one more,
  // so the word landing this edge is fcnt-1.
  assign cap_idx = word_idx_e'(fcnt - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      remaining   <= '0;
      fcnt        <= '0;
      mem_addr    <= '0;
      v1x         <= '0;
      v1y         <= '0;
      v1z         <= '0;
      v2x         <= '0;
      v2y         <= '0;
      v2z         <= '0;
      v3x         <= '0;
      v3y         <= '0;
      v3z         <= '0;
      pixel_color <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            remaining <= num_faces;
            if (num_faces == '0) begin
              frame_done <= 1'b1;
              state      <= FIN;
            end else begin
              busy     <= 1'b1;
              mem_addr <= base_addr;
              ptr      <= base_addr + ADDR_W'(1);
              fcnt     <= '0;
              state    <= FETCH;
            end
          end
        end

        FETCH: begin
          fcnt <= fcnt + 4'd1;
          if (fcnt < LAST_ISSUE) begin
            mem_addr <= ptr;
            ptr      <= ptr + ADDR_W'(1);
          end
          if (fcnt != 4'd0) begin
            case (cap_idx)
              W_V1X:   v1x         <= mem_rdata;
              W_V1Y:   v1y         <= mem_rdata;
              W_V1Z:   v1z         <= mem_rdata;
              W_V2X:   v2x         <= mem_rdata;
              W_V2Y:   v2y         <= mem_rdata;
              W_V2Z:   v2z         <= mem_rdata;
              W_V3X:   v3x         <= mem_rdata;
              W_V3Y:   v3y         <= mem_rdata;
              W_V3Z:   v3z         <= mem_rdata;
              W_COLOR: pixel_color <= mem_rdata;
              default: ;
            endcase
          end
          if (fcnt == LAST_FCNT) begin
            start <= 1'b1;
            state <= LAUNCH;
          end
        end

        LAUNCH: begin
          state <= WAIT;
        end

        WAIT: begin
          if (done) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining != CNT_W'(1)) begin
              mem_addr <= ptr;
              ptr      <= ptr + ADDR_W'(1);
              fcnt     <= '0;
              state    <= FETCH;
            end else begin
              frame_done <= 1'b1;
              state      <= FIN;
            end
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
